rc4_key_search_ctrl: RTL and testbench

// Key-space scheduler wrapped around one arcfour core. Loads a candidate key
// and runs the core until it reports finished. It then scans the decrypted

---
 rtl/rc4_key_search_ctrl_if.sv | 21 ++
 rtl/rc4_key_search_ctrl.sv | 107 ++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_key_search_ctrl_if.sv
// Link between the key-search controller and one arcfour core plus its
// decrypted-message RAM.
interface rc4_key_search_ctrl_if #(
  parameter int unsigned AW = 5
);
  logic [23:0]   key;
  logic          start_sig;
  logic          core_finished;
  logic [AW-1:0] dmem_addr;
  logic [7:0]    dmem_q;

  modport master (
    output key, start_sig, dmem_addr,
    input  core_finished, dmem_q
  );

  modport slave (
    input  key, start_sig, dmem_addr,
    output core_finished, dmem_q
  );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// Key-space scheduler: runs the arcfour core per candidate key, then scans the
// decrypted message for lowercase/space text to accept or advance the key.
module rc4_key_search_ctrl #(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_STEP  = 24'h000001,
  parameter logic [23:0] KEY_LAST  = 24'h3FFFFF,
  parameter int unsigned MSG_LEN   = 32,
  parameter int unsigned AW        = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  rc4_key_search_ctrl_if.master core,
  output logic                 busy,
  output logic                 key_found,
  output logic                 search_fail
);

  typedef enum logic [2:0] {IDLE, RUN, CHECK, NEXT, FOUND, FAIL} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(MSG_LEN - 1);

  state_t        state;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          byte_ok;
  logic [24:0]   key_sum;

  always_comb begin
    byte_ok = (core.dmem_q == 8'h20) || ((core.dmem_q >= 8'h61) && (core.dmem_q <= 8'h7A));
    key_sum = {1'b0, core.key} + {1'b0, KEY_STEP};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      core.key       <= '0;
      core.start_sig <= 1'b0;
      core.dmem_addr <= '0;
      busy           <= 1'b0;
      key_found      <= 1'b0;
      search_fail    <= 1'b0;
      rd_addr        <= '0;
      rd_valid       <= 1'b0;
    end else begin
      case (state)
        IDLE, FOUND, FAIL: begin
          if (start) begin
            state          <= RUN;
            core.key       <= KEY_START;
            core.start_sig <= 1'b1;
            busy           <= 1'b1;
            key_found      <= 1'b0;
            search_fail    <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state          <= IDLE;
            core.start_sig <= 1'b0;
            busy           <= 1'b0;
          end else if (core.core_finished) begin
            state          <= CHECK;
            core.start_sig <= 1'b0;
            core.dmem_addr <= '0;
            rd_valid       <= 1'b0;
          end
        end
        CHECK: begin
          // rd_addr/rd_valid track which address the byte on dmem_q belongs to
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rd_valid && !byte_ok) begin
            state <= NEXT;
          end else if (rd_valid && (rd_addr == LAST_ADDR)) begin
            state     <= FOUND;
            busy      <= 1'b0;
            key_found <= 1'b1;
          end else begin
            rd_valid <= 1'b1;
            rd_addr  <= core.dmem_addr;
            if (core.dmem_addr != LAST_ADDR)
              core.dmem_addr <= core.dmem_addr + 1'b1;
          end
        end
        NEXT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (key_sum > {1'b0, KEY_LAST}) begin
            state       <= FAIL;
            busy        <= 1'b0;
            search_fail <= 1'b1;
          end else begin
            state          <= RUN;
            core.key       <= key_sum[23:0];
            core.start_sig <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Scoreboarded bench: a shared core/RAM model serves four differently
// parameterised controllers, one active at a time.
module tb_rc4_key_search_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] start_v = '0;
  logic [3:0] abort_v = '0;
  logic [3:0] busy_v, found_v, fail_v;

  rc4_key_search_ctrl_if #(.AW(5)) bus0 ();
  rc4_key_search_ctrl_if #(.AW(5)) bus1 ();
  rc4_key_search_ctrl_if #(.AW(5)) bus2 ();
  rc4_key_search_ctrl_if #(.AW(5)) bus3 ();

  rc4_key_search_ctrl dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]), .core(bus0),
    .busy(busy_v[0]), .key_found(found_v[0]), .search_fail(fail_v[0]));

  rc4_key_search_ctrl #(.KEY_LAST(24'h000007)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]), .core(bus1),
    .busy(busy_v[1]), .key_found(found_v[1]), .search_fail(fail_v[1]));

  rc4_key_search_ctrl #(.KEY_START(24'h000001), .KEY_STEP(24'h000002)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .abort(abort_v[2]), .core(bus2),
    .busy(busy_v[2]), .key_found(found_v[2]), .search_fail(fail_v[2]));

  rc4_key_search_ctrl #(.KEY_START(24'h000009), .KEY_LAST(24'h000007)) dut3 (
    .clk(clk), .reset(reset), .start(start_v[3]), .abort(abort_v[3]), .core(bus3),
    .busy(busy_v[3]), .key_found(found_v[3]), .search_fail(fail_v[3]));

  always #5 clk = ~clk;

  // selected-instance view
  logic [1:0]  sel = 2'd0;
  logic [23:0] key_m;
  logic        ss_m;
  logic [4:0]  addr_m;
  logic        busy_m, found_m, fail_m;

  always_comb begin
    case (sel)
      2'd1:    begin key_m = bus1.key; ss_m = bus1.start_sig; addr_m = bus1.dmem_addr; end
      2'd2:    begin key_m = bus2.key; ss_m = bus2.start_sig; addr_m = bus2.dmem_addr; end
      2'd3:    begin key_m = bus3.key; ss_m = bus3.start_sig; addr_m = bus3.dmem_addr; end
      default: begin key_m = bus0.key; ss_m = bus0.start_sig; addr_m = bus0.dmem_addr; end
    endcase
    busy_m  = busy_v[sel];
    found_m = found_v[sel];
    fail_m  = fail_v[sel];
  end

  // core model: finished 10 cycles after start_sig rises, held until it drops
  logic [3:0] cnt = '0;
  logic       fin = 1'b0;
  logic [7:0] q = '0;
  logic [23:0] good_key = 24'hFFFFFF;
  logic [4:0]  bad_idx = 5'd3;
  logic [7:0]  bad_val = 8'h01;

  always @(posedge clk) begin
    if (!ss_m) begin
      cnt <= '0;
      fin <= 1'b0;
    end else begin
      if (cnt != 4'd10) cnt <= cnt + 4'd1;
      fin <= (cnt >= 4'd9);
    end
    if (key_m == good_key)     q <= 8'h61;
    else if (addr_m == bad_idx) q <= bad_val;
    else                        q <= 8'h61;
  end

  assign bus0.core_finished = fin;
  assign bus1.core_finished = fin;
  assign bus2.core_finished = fin;
  assign bus3.core_finished = fin;
  assign bus0.dmem_q = q;
  assign bus1.dmem_q = q;
  assign bus2.dmem_q = q;
  assign bus3.dmem_q = q;

  int vectors = 0;
  int miscompares = 0;
  int runs = 0;
  int gap = 0;
  logic prev_ss = 1'b0;
  logic [23:0] exp_keys[$];
  int gaps[$];

  // scoreboard: each rising start_sig pops the expected candidate key;
  // gaps records busy cycles with start_sig low (CHECK+NEXT, or CHECK alone before FOUND)
  always @(negedge clk) begin
    if (ss_m && !prev_ss) begin
      runs++;
      vectors++;
      if (exp_keys.size() == 0) begin
        miscompares++;
        $display("FAIL run_key: unexpected run with key %h, none expected", key_m);
      end else begin
        logic [23:0] ek;
        ek = exp_keys.pop_front();
        if (key_m !== ek) begin
          miscompares++;
          $display("FAIL run_key: got %h want %h", key_m, ek);
        end
      end
    end
    prev_ss = ss_m;
    if (busy_m && !ss_m) gap++;
    else begin
      if (gap != 0) gaps.push_back(gap);
      gap = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_keys.delete();
    gaps.delete();
    runs = 0;
  endtask

  task automatic push_keys(input logic [23:0] first, input logic [23:0] step, input int n);
    for (int i = 0; i < n; i++) exp_keys.push_back(first + step * 24'(i));
  endtask

  task automatic pulse_start();
    start_v[sel] = 1'b1;
    tick();
    start_v[sel] = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_v[sel] = 1'b1;
    tick();
    abort_v[sel] = 1'b0;
  endtask

  // mode 0: search ended; 1: in CHECK; 2: runs reached n
  task automatic wait_for(input int mode, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((mode == 0 && (found_m || fail_m)) ||
          (mode == 1 && busy_m && !ss_m) ||
          (mode == 2 && runs >= n)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    for (int unsigned s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      vectors++;
      ok = (key_m === 24'h0) && (ss_m === 1'b0) && (addr_m === 5'd0) &&
           (busy_m === 1'b0) && (found_m === 1'b0) && (fail_m === 1'b0);
      if (!ok) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: key=%h ss=%b addr=%0d busy=%b found=%b fail=%b want all 0",
                 s, key_m, ss_m, addr_m, busy_m, found_m, fail_m);
      end
    end
    sel = 2'd0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_find_key();
    bit ok;
    sel = 2'd0; good_key = 24'h5; bad_idx = 5'd3; bad_val = 8'h01;
    clear_sb();
    push_keys(24'h0, 24'h1, 6);
    pulse_start();
    wait_for(0, 0, 3000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL find_timeout: got no end want found"); end
    vectors++;
    if (found_m !== 1'b1 || fail_m !== 1'b0 || key_m !== 24'h5) begin
      miscompares++;
      $display("FAIL find_result: found=%b fail=%b key=%h want 1 0 000005", found_m, fail_m, key_m);
    end
    vectors++;
    if (runs != 6 || exp_keys.size() != 0) begin
      miscompares++;
      $display("FAIL find_runs: runs=%0d left=%0d want 6 0", runs, exp_keys.size());
    end
    vectors++;
    if (gaps.size() != 6 || gaps[0] != 6 || gaps[4] != 6 || gaps[5] != 33) begin
      miscompares++;
      $display("FAIL find_gaps: n=%0d g0=%0d g5=%0d want 6 6 33", gaps.size(),
               (gaps.size() > 0) ? gaps[0] : -1, (gaps.size() > 5) ? gaps[5] : -1);
    end
  endtask

  task automatic test_exhaust();
    bit ok;
    sel = 2'd1; good_key = 24'hFFFFFF; bad_idx = 5'd3; bad_val = 8'h01;
    clear_sb();
    push_keys(24'h0, 24'h1, 8);
    pulse_start();
    wait_for(0, 0, 3000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL exhaust_timeout: got no end want fail"); end
    vectors++;
    if (fail_m !== 1'b1 || found_m !== 1'b0 || key_m !== 24'h7 || busy_m !== 1'b0) begin
      miscompares++;
      $display("FAIL exhaust_result: fail=%b found=%b key=%h busy=%b want 1 0 000007 0",
               fail_m, found_m, key_m, busy_m);
    end
    vectors++;
    if (runs != 8 || exp_keys.size() != 0) begin
      miscompares++;
      $display("FAIL exhaust_runs: runs=%0d left=%0d want 8 0", runs, exp_keys.size());
    end
  endtask

  task automatic test_first_byte_reject();
    bit ok;
    sel = 2'd0; good_key = 24'h1; bad_idx = 5'd0; bad_val = 8'hFF;
    clear_sb();
    push_keys(24'h0, 24'h1, 2);
    pulse_start();
    wait_for(0, 0, 1000, ok);
    vectors++;
    if (!ok || found_m !== 1'b1 || key_m !== 24'h1) begin
      miscompares++;
      $display("FAIL byte0_result: ok=%b found=%b key=%h want 1 1 000001", ok, found_m, key_m);
    end
    // 2 CHECK cycles + 1 NEXT cycle
    vectors++;
    if (gaps.size() != 2 || gaps[0] != 3) begin
      miscompares++;
      $display("FAIL byte0_gap: n=%0d g0=%0d want 2 3", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
    end
  endtask

  task automatic test_byte_sweep();
    logic [7:0] vals[7] = '{8'h20, 8'h61, 8'h7A, 8'h1F, 8'h60, 8'h7B, 8'hFF};
    bit ok;
    sel = 2'd0; good_key = 24'hFFFFFF; bad_idx = 5'd31;
    for (int i = 0; i < 7; i++) begin
      bad_val = vals[i];
      clear_sb();
      if (i < 3) begin
        push_keys(24'h0, 24'h1, 1);
        pulse_start();
        wait_for(0, 0, 500, ok);
        vectors++;
        if (!ok || found_m !== 1'b1 || key_m !== 24'h0 || gaps.size() != 1 || gaps[0] != 33) begin
          miscompares++;
          $display("FAIL sweep_pass[%h]: ok=%b found=%b key=%h ngaps=%0d want found key 0 gap 33",
                   vals[i], ok, found_m, key_m, gaps.size());
        end
      end else begin
        push_keys(24'h0, 24'h1, 2);
        pulse_start();
        wait_for(2, 2, 500, ok);
        pulse_abort();
        vectors++;
        if (!ok || busy_m !== 1'b0 || found_m !== 1'b0 || key_m !== 24'h1 || ss_m !== 1'b0) begin
          miscompares++;
          $display("FAIL sweep_reject[%h]: ok=%b busy=%b found=%b key=%h ss=%b want 1 0 0 000001 0",
                   vals[i], ok, busy_m, found_m, key_m, ss_m);
        end
        // last byte checked: 33 CHECK cycles + NEXT
        vectors++;
        if (gaps.size() < 1 || gaps[0] != 34) begin
          miscompares++;
          $display("FAIL sweep_gap[%h]: n=%0d g0=%0d want 34", vals[i], gaps.size(),
                   (gaps.size() > 0) ? gaps[0] : -1);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    sel = 2'd0; good_key = 24'h5; bad_idx = 5'd3; bad_val = 8'h01;
    for (int unsigned m = 0; m < 2; m++) begin
      clear_sb();
      push_keys(24'h0, 24'h1, 6);
      pulse_start();
      if (m == 0) begin tick(); tick(); ok = 1'b1; end
      else wait_for(1, 0, 500, ok);
      reset = 1'b1;
      #1;
      vectors++;
      if (!ok || ss_m !== 1'b0 || busy_m !== 1'b0 || found_m !== 1'b0 || fail_m !== 1'b0 || key_m !== 24'h0) begin
        miscompares++;
        $display("FAIL async_reset[%0d]: ok=%b ss=%b busy=%b found=%b fail=%b key=%h want 1 0 0 0 0 0",
                 m, ok, ss_m, busy_m, found_m, fail_m, key_m);
      end
      tick();
      reset = 1'b0;
      tick();
    end
    clear_sb();
    push_keys(24'h0, 24'h1, 6);
    pulse_start();
    wait_for(0, 0, 3000, ok);
    vectors++;
    if (!ok || found_m !== 1'b1 || key_m !== 24'h5 || runs != 6) begin
      miscompares++;
      $display("FAIL reset_restart: ok=%b found=%b key=%h runs=%0d want 1 1 000005 6", ok, found_m, key_m, runs);
    end
  endtask

  task automatic test_control();
    bit ok;
    sel = 2'd0; good_key = 24'h2; bad_idx = 5'd3; bad_val = 8'h01;
    clear_sb();
    push_keys(24'h0, 24'h1, 3);
    pulse_start();
    wait_for(1, 0, 500, ok);
    pulse_start();
    wait_for(0, 0, 2000, ok);
    vectors++;
    if (!ok || found_m !== 1'b1 || key_m !== 24'h2 || runs != 3) begin
      miscompares++;
      $display("FAIL busy_start: ok=%b found=%b key=%h runs=%0d want 1 1 000002 3", ok, found_m, key_m, runs);
    end
    pulse_abort();
    tick();
    vectors++;
    if (found_m !== 1'b1 || key_m !== 24'h2 || busy_m !== 1'b0) begin
      miscompares++;
      $display("FAIL found_abort: found=%b key=%h busy=%b want 1 000002 0", found_m, key_m, busy_m);
    end
    clear_sb();
    push_keys(24'h0, 24'h1, 3);
    pulse_start();
    vectors++;
    if (found_m !== 1'b0 || key_m !== 24'h0 || busy_m !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_found: found=%b key=%h busy=%b want 0 000000 1", found_m, key_m, busy_m);
    end
    wait_for(0, 0, 2000, ok);
    vectors++;
    if (!ok || found_m !== 1'b1 || key_m !== 24'h2) begin
      miscompares++;
      $display("FAIL restart_result: ok=%b found=%b key=%h want 1 1 000002", ok, found_m, key_m);
    end
    good_key = 24'hFFFFFF;
    clear_sb();
    push_keys(24'h0, 24'h1, 1);
    pulse_start();
    wait_for(1, 0, 500, ok);
    pulse_abort();
    vectors++;
    if (!ok || busy_m !== 1'b0 || ss_m !== 1'b0 || found_m !== 1'b0 || fail_m !== 1'b0 || key_m !== 24'h0) begin
      miscompares++;
      $display("FAIL check_abort: ok=%b busy=%b ss=%b found=%b fail=%b key=%h want 1 0 0 0 0 000000",
               ok, busy_m, ss_m, found_m, fail_m, key_m);
    end
    for (int i = 0; i < 20; i++) tick();
    vectors++;
    if (runs != 1 || busy_m !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: runs=%0d busy=%b want 1 0", runs, busy_m);
    end
  endtask

  task automatic test_key_step();
    bit ok;
    sel = 2'd2; good_key = 24'h5; bad_idx = 5'd3; bad_val = 8'h01;
    clear_sb();
    push_keys(24'h1, 24'h2, 3);
    pulse_start();
    wait_for(0, 0, 2000, ok);
    vectors++;
    if (!ok || found_m !== 1'b1 || key_m !== 24'h5 || runs != 3 || exp_keys.size() != 0) begin
      miscompares++;
      $display("FAIL key_step: ok=%b found=%b key=%h runs=%0d want 1 1 000005 3", ok, found_m, key_m, runs);
    end
  endtask

  task automatic test_start_past_last();
    bit ok;
    sel = 2'd3; good_key = 24'hFFFFFF; bad_idx = 5'd3; bad_val = 8'h01;
    clear_sb();
    push_keys(24'h9, 24'h1, 1);
    pulse_start();
    wait_for(0, 0, 1000, ok);
    vectors++;
    if (!ok || fail_m !== 1'b1 || found_m !== 1'b0 || key_m !== 24'h9 || runs != 1) begin
      miscompares++;
      $display("FAIL start_past_last: ok=%b fail=%b found=%b key=%h runs=%0d want 1 1 0 000009 1",
               ok, fail_m, found_m, key_m, runs);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_find_key();
    test_exhaust();
    test_first_byte_reject();
    test_byte_sweep();
    test_async_reset();
    test_control();
    test_key_step();
    test_start_past_last();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
